// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline boundary with two-entry skid buffer
//
// Selects the shifter or ALU result and captures it with the destination and
// memory-control fields. The result goes to the MEM stage through a
// valid/ready handshake. Because of the main/skid register pair, in_ready
// comes only from registered state, so MEM back-pressure never reaches EX
// combinationally.
//
// Optional feature macro: EX_MEM_STALL_CNT_EN adds a saturating 16-bit
// stall_cnt output that counts cycles with out_valid & ~out_ready.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               squash all held entries, drop any same-cycle input
//   in_valid/in_ready   EX-side handshake
//   in_sel_shift        1 = in_shift_out, 0 = in_alu_out
//   in_shift_out, in_alu_out, in_store_data (32), in_rd (5)
//   in_reg_write, in_mem_read, in_mem_write
//   out_valid/out_ready MEM-side handshake
//   out_result, out_store_data (32), out_rd (5)
//   out_reg_write, out_mem_read, out_mem_write
//   stall_cnt (16)      only with EX_MEM_STALL_CNT_EN

module ex_mem_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sel_shift,
    input  logic [31:0] in_shift_out,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } entry_t;

    // ONE means main valid only; FULL means main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;

    logic w_accept;
    logic w_transfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Only the muxed result is stored. Writes to $0 never reach the register file.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.result     = in_sel_shift ? in_shift_out : in_alu_out;
        w_in_entry.store_data = in_store_data;
        w_in_entry.rd         = in_rd;
        w_in_entry.reg_write  = in_reg_write & (in_rd != 5'd0);
        w_in_entry.mem_read   = in_mem_read;
        w_in_entry.mem_write  = in_mem_write;
    end

    assign out_valid = (r_state != ST_EMPTY);
    // in_ready depends on registered state and rst_n only.
    assign in_ready  = rst_n & (r_state != ST_FULL);

    // A flushed cycle never accepts, even when in_ready reads 1.
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_transfer = out_valid & out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_transfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_transfer) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No accept is possible here because in_ready is low.
                    if (w_transfer) begin
                        w_next_state     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign out_result     = r_main.result;
    assign out_store_data = r_main.store_data;
    assign out_rd         = r_main.rd;
    assign out_reg_write  = r_main.reg_write;
    assign out_mem_read   = r_main.mem_read;
    assign out_mem_write  = r_main.mem_write;

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Flush does not clear the counter. It saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - self-checking bench for ex_mem_skid

module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel_shift;
    logic [31:0] in_shift_out;
    logic [31:0] in_alu_out;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
    int          m_stall;
`endif

    always #5 clk = ~clk;

    ex_mem_skid dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sel_shift   (in_sel_shift),
        .in_shift_out   (in_shift_out),
        .in_alu_out     (in_alu_out),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ent_t;

    // Reference model: a FIFO of at most two held instructions.
    ent_t mq[$];

    typedef struct {
        logic        sel;
        logic [31:0] shift;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] exp_result;
        logic        exp_rw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic ent_t make_entry();
        ent_t e;
        e.result     = in_sel_shift ? in_shift_out : in_alu_out;
        e.store_data = in_store_data;
        e.rd         = in_rd;
        e.reg_write  = in_reg_write && (in_rd != 5'd0);
        e.mem_read   = in_mem_read;
        e.mem_write  = in_mem_write;
        return e;
    endfunction

    task automatic compare_model();
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, rst_n && (mq.size() < 2)});
        if (mq.size() > 0) begin
            chk("out_result", out_result, mq[0].result);
            chk("out_store_data", out_store_data, mq[0].store_data);
            chk("out_rd", {27'd0, out_rd}, {27'd0, mq[0].rd});
            chk("out_ctl", {29'd0, out_reg_write, out_mem_read, out_mem_write},
                {29'd0, mq[0].reg_write, mq[0].mem_read, mq[0].mem_write});
        end
`ifdef EX_MEM_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    endtask

    // One clock: model advances from the inputs present before the edge,
    // DUT outputs are compared 1 ns after the edge.
    task automatic cycle();
        bit   acc, xfer, stall;
        ent_t e;
        acc   = rst_n && in_valid && !flush && (mq.size() < 2);
        xfer  = (mq.size() > 0) && out_ready;
        stall = (mq.size() > 0) && !out_ready;
        e     = make_entry();
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
`ifdef EX_MEM_STALL_CNT_EN
            m_stall = 0;
`endif
        end else begin
`ifdef EX_MEM_STALL_CNT_EN
            if (stall && m_stall != 16'hFFFF) m_stall++;
`endif
            if (flush) mq.delete();
            else begin
                if (xfer) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end
        #1;
        compare_model();
        if (stall) begin end
    endtask

    task automatic drive(input logic [31:0] alu);
        in_valid     = 1'b1;
        in_sel_shift = 1'b0;
        in_alu_out   = alu;
        in_shift_out = ~alu;
        in_rd        = 5'd3;
        in_reg_write = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sel_shift = 1'b0; in_shift_out = '0; in_alu_out = '0;
        in_store_data = '0; in_rd = '0; in_reg_write = 1'b0;
        in_mem_read = 1'b0; in_mem_write = 1'b0;
`ifdef EX_MEM_STALL_CNT_EN
        m_stall = 0;
`endif
        vecs[0] = '{1'b1, 32'h0000_0F00, 32'h0000_DEAD, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0000_0F00, 1'b1};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0002, 32'h0000_1000, 32'hCAFE_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0003, 32'h0000_2004, 32'h0, 5'd17, 1'b1, 1'b1, 1'b0, 32'h0000_2004, 1'b1};

        // Reset state
        cycle();
        cycle();
        chk("reset_out_result", out_result, 32'h0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // Table-driven single passes
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_sel_shift = vecs[i].sel; in_shift_out = vecs[i].shift;
            in_alu_out = vecs[i].alu; in_store_data = vecs[i].store; in_rd = vecs[i].rd;
            in_reg_write = vecs[i].rw; in_mem_read = vecs[i].mr; in_mem_write = vecs[i].mw;
            cycle();
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp_result);
            chk($sformatf("vec%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("vec%0d_rw", i), {31'd0, out_reg_write}, {31'd0, vecs[i].exp_rw});
            chk($sformatf("vec%0d_store", i), out_store_data, vecs[i].store);
            in_valid = 1'b0;
            cycle();
        end
        in_store_data = '0; in_mem_read = 1'b0; in_mem_write = 1'b0;

        // Back-pressure: A held, B in skid, C waits
        out_ready = 1'b0;
        drive(32'h1); cycle();
        chk("bp_a_out", out_result, 32'h1);
        drive(32'h2); cycle();
        chk("bp_a_held", out_result, 32'h1);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        drive(32'h3); cycle();
        chk("bp_a_still", out_result, 32'h1);
        chk("bp_c_waits", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1; cycle();
        chk("bp_b_out", out_result, 32'h2);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        cycle();
        in_valid = 1'b0;
        chk("bp_c_out", out_result, 32'h3);
        chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
        cycle();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with a presented input
        out_ready = 1'b0;
        drive(32'h10); cycle();
        drive(32'h11); cycle();
        drive(32'h99); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1; cycle(); cycle();
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);
        // Flush in ONE: in_ready reads 1 but the input is still dropped
        out_ready = 1'b0;
        drive(32'h20); cycle();
        drive(32'h21); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0; cycle();
        chk("flush_one_dropped", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        drive(32'h30); cycle();
        drive(32'h31); cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        cycle();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'h0);
`ifdef EX_MEM_STALL_CNT_EN
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_high", {31'd0, in_ready}, 32'd1);
        drive(32'h40); out_ready = 1'b1; cycle();
        chk("rst_first_accept", out_result, 32'h40);
        in_valid = 1'b0; cycle();

        // Randomized against the queue model
        for (int n = 0; n < 3000; n++) begin
            if (!(in_valid && rst_n && mq.size() >= 2)) begin
                in_valid      = ($urandom_range(0, 3) != 0);
                in_sel_shift  = $urandom_range(0, 1);
                in_shift_out  = $urandom;
                in_alu_out    = $urandom;
                in_store_data = $urandom;
                in_rd         = $urandom_range(0, 31);
                in_reg_write  = $urandom_range(0, 1);
                in_mem_read   = $urandom_range(0, 1);
                in_mem_write  = $urandom_range(0, 1);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle();

`ifdef EX_MEM_STALL_CNT_EN
        // Saturation: hold one valid entry with out_ready low
        drive(32'h55); cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        repeat (70000) @(posedge clk);
        #1;
        m_stall = (m_stall + 70000 > 65535) ? 65535 : m_stall + 70000;
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        repeat (10) cycle();
        chk("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("stall_no_flush_clear", {16'd0, stall_cnt}, 32'h0000_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
